// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles a length-prefixed big-endian
// byte stream into 32-bit words and holds the CPU in reset until loading ends.
module imem_loader #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // state  | meaning
  // LEN_HI | waiting for word-count MSB
  // LEN_LO | waiting for word-count LSB, then range check
  // WORD   | collecting the 4 bytes of the current word
  // WRITE  | write strobe cycle, input stalled
  // DONE   | image loaded, CPU released
  // ERR    | length rejected, CPU held
  typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD, WRITE, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic [15:0] len_full;
  logic        accept;

  assign len_full = {len[15:8], in_data};
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!reset && (state == LEN_HI || state == LEN_LO || state == WORD))
      in_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LEN_HI;
      len       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
            byte_idx <= '0;
            word_idx <= '0;
            if (len_full == 16'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if ({1'b0, len_full} > DEPTH_LIM) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= WORD;
            end
          end
        end
        WORD: begin
          if (accept) begin
            word_buf <= {word_buf[23:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            // Strobe is registered on the 4th byte so it is live for the WRITE cycle.
            if (byte_idx == 2'd3) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= {14'b0, word_idx, 2'b00};
              mem_wdata <= {word_buf[23:0], in_data};
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          byte_idx <= '0;
          if (word_idx + 16'd1 == len) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= WORD;
          end
        end
        DONE, ERR: state <= state;
        default:   state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven,
// popped and compared whenever the loader strobes mem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  int          we_cnt = 0;
  int          cyc = 0;
  int          acc_since_rst = 0;
  int          first_acc_cyc = 0;
  int          done_cyc = 0;
  logic        done_prev = 1'b0;

  imem_loader #(.DEPTH(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (reset) begin
      acc_since_rst = 0;
    end else if (in_valid && in_ready) begin
      if (acc_since_rst == 0) first_acc_cyc = cyc;
      acc_since_rst++;
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
    if (mem_we) begin
      we_cnt++;
      check("ready_in_write", {31'b0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit rnd);
    exp_q.push_back({addr, w});
    for (int k = 3; k >= 0; k--)
      send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_three(input bit rnd);
    logic [31:0] words [3];
    words[0] = 32'h01234567;
    words[1] = 32'h89ABCDEF;
    words[2] = 32'hCAFEF00D;
    send_byte(8'h00, rnd ? 2 : 0);
    send_byte(8'h03, rnd ? 1 : 0);
    for (int i = 0; i < 3; i++) send_word(32'(4 * i), words[i], rnd);
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_mem_we",   {31'b0, mem_we},   32'd0);
    check("rst_mem_addr", mem_addr,          32'd0);
    check("rst_mem_wdata", mem_wdata,        32'd0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_error",    {31'b0, error},    32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single word
    base = we_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h0, 32'h20080005, 0);
    in_valid = 1'b0;
    wait_done();
    check("one_done", {31'b0, done}, 32'd1);
    check("one_hold", {31'b0, cpu_hold}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("one_ready_after", {31'b0, in_ready}, 32'd0);
    check("one_we_count", 32'(we_cnt - base), 32'd1);

    // Three words, continuous
    do_reset();
    base = we_cnt;
    load_three(0);
    wait_done();
    check("three_we_count", 32'(we_cnt - base), 32'd3);
    check("three_done_lat", 32'(done_cyc - first_acc_cyc), 32'd17);
    check("three_hold", {31'b0, cpu_hold}, 32'd0);

    // Three words, random valid gaps
    do_reset();
    base = we_cnt;
    load_three(1);
    wait_done();
    check("gap_we_count", 32'(we_cnt - base), 32'd3);
    check("gap_acc_count", 32'(acc_since_rst), 32'd14);

    // Zero-length image
    do_reset();
    base = we_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_hold", {31'b0, cpu_hold}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    check("zero_ready", {31'b0, in_ready}, 32'd0);
    idle(3);
    check("zero_we_count", 32'(we_cnt - base), 32'd0);

    // Exactly DEPTH words is accepted
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("depth_error", {31'b0, error}, 32'd0);
    check("depth_ready", {31'b0, in_ready}, 32'd1);

    // DEPTH+1 words is rejected
    do_reset();
    base = we_cnt;
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(negedge clk);
    check("err_error", {31'b0, error}, 32'd1);
    check("err_hold",  {31'b0, cpu_hold}, 32'd1);
    check("err_ready", {31'b0, in_ready}, 32'd0);
    idle(4);
    check("err_we_count", 32'(we_cnt - base), 32'd0);
    do_reset();
    @(negedge clk);
    check("err_cleared", {31'b0, error}, 32'd0);
    check("err_rst_ready", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of word 1
    do_reset();
    base = we_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h0, 32'h0BADF00D, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    do_reset();
    idle(3);
    check("mid_we_count", 32'(we_cnt - base), 32'd1);
    check("mid_hold", {31'b0, cpu_hold}, 32'd1);
    check("mid_done", {31'b0, done}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h0, 32'hDEADBEEF, 0);
    in_valid = 1'b0;
    wait_done();
    check("mid_reload_done", {31'b0, done}, 32'd1);
    check("mid_reload_we", 32'(we_cnt - base), 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
